cacheline_adapter: RTL

- Sits between the cache and the banked memory model (`bmem_*` interface) once caches are integrated into `cpu`.
- Converts one full cacheline request from the cache (downstream fill/writeback port, `dfp_*`) into a BEATS-beat burst on `bmem_*`, and back.
- Assembles read beats into a line. Serialises write lines into beats.
- One outstanding request at a time.

---
 rtl/cacheline_adapter_pkg.sv | 22 ++
 rtl/cacheline_adapter.sv | 117 +++++++++++
 2 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared widths, line/beat types and adapter FSM encoding for the
// cacheline <-> bmem burst adapter.
package cacheline_adapter_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned BEAT_BITS   = 64;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BEATS       = LINE_BITS / BEAT_BITS;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cacheline request from the cache into a BEATS-beat burst on the
// banked memory interface; assembles read beats, serialises write lines.
module cacheline_adapter #(
    parameter int unsigned LINE_BITS  = cacheline_adapter_pkg::LINE_BITS,
    parameter int unsigned BEAT_BITS  = cacheline_adapter_pkg::BEAT_BITS,
    parameter int unsigned ADDR_WIDTH = cacheline_adapter_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_BITS-1:0]  dfp_wdata,
    output logic [LINE_BITS-1:0]  dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_BITS-1:0]  bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_BITS-1:0]  bmem_rdata,
    input  logic                  bmem_rvalid
);
    import cacheline_adapter_pkg::*;

    localparam int unsigned NBEATS   = LINE_BITS / BEAT_BITS;
    localparam int unsigned LINE_OFF = $clog2(LINE_BITS / 8);
    localparam int unsigned CNT_W    = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    adapter_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0]  wline_q, wline_d;
    logic [LINE_BITS-1:0]  rline_q, rline_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] dfp_addr_aligned;

    assign dfp_addr_aligned = {dfp_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign dfp_rdata        = rline_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wline_d    = wline_q;
        rline_d    = rline_q;
        cnt_d      = cnt_q;
        bmem_addr  = addr_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                // Write wins a simultaneous request; a held read is taken on the next IDLE.
                if (dfp_write) begin
                    addr_d  = dfp_addr_aligned;
                    wline_d = dfp_wdata;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (dfp_read) begin
                    addr_d  = dfp_addr_aligned;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    rline_d[cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_wdata = wline_q[cnt_q*BEAT_BITS +: BEAT_BITS];
                if (bmem_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
